mac_job_sequencer: RTL and testbench
====================================

// Module: mac_job_sequencer
// PURPOSE
// Host-side initiator for the MAC controller/datapath. It buffers one job of operand pairs, then drives
// the MAC start/stop/reset handshake and streams one pair per cycle while the MAC is busy. It captures
// the accumulated result on done and returns it over a valid/ready port. Sits between the stimulus or
// bus side and the MAC core.
// PARAMETERS
// DATA_W  8   operand width (a, b)
// ACC_W   20  accumulator/result width
// DEPTH   16  operand-pair buffer depth; maximum job length
// LEN_W   5   job_len width; must satisfy 2**LEN_W > DEPTH
// TMO     15  max cycles to wait for mac_busy or mac_done before error
// PORTS
// clk        in   1       clock, rising edge
// rst        in   1       asynchronous reset, active high
// job_start  in   1       start-of-job request, sampled in IDLE only
// job_len    in   LEN_W   number of pairs in the job; legal range 1..DEPTH
// in_valid   in   1       operand pair valid
// in_ready   out  1       sequencer accepts the pair
// in_a/in_b  in   DATA_W  operand pair
// mac_rst    out  1       MAC synchronous reset
// mac_go     out  1       MAC go
// mac_stop   out  1       MAC stop
// mac_a/mac_b out DATA_W  operands presented to the MAC
// mac_busy   in   1       MAC busy
// mac_done   in   1       MAC done
// mac_result in   ACC_W   MAC accumulated output
// res_valid  out  1       result valid
// res_ready  in   1       result accepted
// res_data   out  ACC_W   registered result
// busy       out  1       high in every state except IDLE
// err        out  1       one-cycle error pulse
// BEHAVIOUR
// - Reset: state=IDLE, count and pointers 0, res_data=0; all outputs 0 except mac_rst=1.
//   mac_rst = rst | (state==CLR), so the MAC returns to its idle state whenever this block is reset.
// - FSM: IDLE -> FILL -> CLR -> ARM -> STREAM -> STOP -> RESULT -> IDLE.
// - IDLE: job_start with 1<=job_len<=DEPTH latches len and goes to FILL.
//   An illegal len pulses err for 1 cycle and stays in IDLE. job_start outside IDLE is ignored.
// - FILL: in_ready=1. A pair is written on in_valid&in_ready. Gaps in in_valid are allowed.
//   When the len-th pair is accepted, in_ready drops the next cycle and the FSM goes to CLR.
// - CLR: mac_rst=1 for exactly 1 cycle, then ARM.
// - ARM: mac_go=1 until mac_busy is seen, then STREAM. If mac_busy is not seen within TMO cycles:
//   err pulse, and CLR then IDLE.
// - STREAM: on the first cycle with mac_busy=1, present pair 0 on mac_a/mac_b, then pair k on cycle k.
//   mac_stop=1 combinationally in the cycle the last pair (len-1) is presented, then STOP.
//   Outside STREAM, mac_a and mac_b are 0.
// - STOP: wait for mac_done. On mac_done, res_data<=mac_result, then RESULT.
//   Timeout TMO: err pulse, and CLR then IDLE.
// - RESULT: res_valid=1 with res_data held stable until res_ready. Handshake completes in that cycle.
//   The next cycle is IDLE.
// - Latency: job_start to first mac_go = len + 2 cycles minimum (with in_valid held high).
//   go to done = len + 3 cycles nominal.
// - Result width: mac_result is taken verbatim. Overflow wraps modulo 2**ACC_W. No saturation.
// - Async rst mid-job: abandon the job immediately, flush the buffer, discard any pending result.
// PARAMETERS CHECK: DEPTH < 2**LEN_W; DATA_W, ACC_W > 0.
// TESTING
// T1 len=4, pairs (1,2),(3,4),(5,6),(7,8), res_ready=1 -> res_data=100, one res_valid cycle, busy then 0
// T2 len=0 and len=DEPTH+1 -> err 1-cycle pulse each, in_ready stays 0, no mac_go
// T3 len=3, in_valid toggling 1,0,1,0,1 -> all 3 pairs captured, order kept, pairs (2,3)x3 -> 18
// T4 res_ready low 5 cycles -> res_valid/res_data stable; next job_start ignored until accept
// T5 rst pulsed mid-STREAM -> all outputs reset, mac_rst=1 during rst; next job len=2 (4,4),(1,1) -> 17
// T6 MAC model never raises mac_done -> err pulse after TMO cycles in STOP, mac_rst pulse, back to IDLE

Source files
------------

// File: rtl/mac_job_sequencer_if.sv
// Host, MAC and result signals of the MAC job sequencer, bundled as one port.
// The master modport is the sequencer's view of the bus, and the slave modport is the view from the host and MAC side.
interface mac_job_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int LEN_W  = 5
) ();
    logic              job_start;
    logic [LEN_W-1:0]  job_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              mac_rst;
    logic              mac_go;
    logic              mac_stop;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic              mac_busy;
    logic              mac_done;
    logic [ACC_W-1:0]  mac_result;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;

    modport master (
        input  job_start, job_len, in_valid, in_a, in_b,
        input  mac_busy, mac_done, mac_result, res_ready,
        output in_ready, mac_rst, mac_go, mac_stop, mac_a, mac_b,
        output res_valid, res_data
    );

    modport slave (
        output job_start, job_len, in_valid, in_a, in_b,
        output mac_busy, mac_done, mac_result, res_ready,
        input  in_ready, mac_rst, mac_go, mac_stop, mac_a, mac_b,
        input  res_valid, res_data
    );
endinterface

// File: rtl/mac_job_sequencer.sv
// Buffers one job of operand pairs and runs it through the MAC: clear, arm, stream, stop.
// The result is then returned on a valid/ready port.
module mac_job_sequencer #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 5,
    parameter int TMO    = 15
) (
    input  logic                clk,
    input  logic                rst,
    mac_job_sequencer_if.master bus,
    output logic                busy,
    output logic                err
);

    if (DEPTH >= (1 << LEN_W) || DEPTH < 1 || DATA_W < 1 || ACC_W < 1 || TMO < 1) begin : g_bad_params
        $error("mac_job_sequencer: illegal parameter combination");
    end

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TMO + 1);
    localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TMO - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_CLR    = 3'd2;
    localparam logic [2:0] S_ARM    = 3'd3;
    localparam logic [2:0] S_STREAM = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;
    localparam logic [2:0] S_RESULT = 3'd6;

    logic [2:0]        state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  wr_ptr;
    logic [LEN_W-1:0]  rd_ptr;
    logic [TW-1:0]     tmo_cnt;
    logic              abort_q;
    logic [ACC_W-1:0]  res_q;
    logic [DATA_W-1:0] mem_a [0:DEPTH-1];
    logic [DATA_W-1:0] mem_b [0:DEPTH-1];

    logic             len_ok;
    logic [LEN_W-1:0] last_idx;
    logic             tmo_hit;

    assign len_ok   = (bus.job_len != '0) && (bus.job_len <= DEPTH_L);
    assign last_idx = len_q - LEN_W'(1);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    // NOTE: every register below is updated with <= so that all of them sample the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            len_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tmo_cnt <= '0;
            abort_q <= 1'b0;
            res_q   <= '0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.job_start) begin
                        if (len_ok) begin
                            len_q   <= bus.job_len;
                            wr_ptr  <= '0;
                            abort_q <= 1'b0;
                            state   <= S_FILL;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (bus.in_valid) begin
                        wr_ptr <= wr_ptr + LEN_W'(1);
                        if (wr_ptr == last_idx) state <= S_CLR;
                    end
                end
                S_CLR: begin
                    // A timed-out job passes through CLR only to reset the MAC before going idle.
                    tmo_cnt <= '0;
                    rd_ptr  <= '0;
                    wr_ptr  <= '0;
                    state   <= abort_q ? S_IDLE : S_ARM;
                end
                S_ARM: begin
                    if (bus.mac_busy) begin
                        state <= S_STREAM;
                    end else if (tmo_hit) begin
                        err     <= 1'b1;
                        abort_q <= 1'b1;
                        state   <= S_CLR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_STREAM: begin
                    rd_ptr <= rd_ptr + LEN_W'(1);
                    if (rd_ptr == last_idx) begin
                        tmo_cnt <= '0;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bus.mac_done) begin
                        res_q <= bus.mac_result;
                        state <= S_RESULT;
                    end else if (tmo_hit) begin
                        err     <= 1'b1;
                        abort_q <= 1'b1;
                        state   <= S_CLR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the operand buffer has no reset; it is flushed by clearing the pointers, and stale entries are never read.
    always_ff @(posedge clk) begin
        if (state == S_FILL && bus.in_valid) begin
            mem_a[wr_ptr[AW-1:0]] <= bus.in_a;
            mem_b[wr_ptr[AW-1:0]] <= bus.in_b;
        end
    end

    // NOTE: each output gets a default before the conditional assignment, so no latch is inferred.
    always_comb begin
        bus.mac_a    = '0;
        bus.mac_b    = '0;
        bus.mac_stop = 1'b0;
        if (state == S_STREAM) begin
            bus.mac_a    = mem_a[rd_ptr[AW-1:0]];
            bus.mac_b    = mem_b[rd_ptr[AW-1:0]];
            bus.mac_stop = (rd_ptr == last_idx);
        end
    end

    assign bus.in_ready  = (state == S_FILL);
    assign bus.mac_rst   = rst | (state == S_CLR);
    assign bus.mac_go    = (state == S_ARM);
    assign bus.res_valid = (state == S_RESULT);
    assign bus.res_data  = res_q;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a behavioural MAC model.
// Expected results go into a queue, and a negedge monitor checks them against each accepted res_data.
module tb_mac_job_sequencer;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = 5;
    localparam int TMO    = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err;

    mac_job_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    mac_job_sequencer #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .TMO(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master),
        .busy(busy),
        .err (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] exp_q[$];
    int rv_cycles = 0;
    int go_cycles = 0;
    logic [DATA_W-1:0] pa [0:DEPTH-1];
    logic [DATA_W-1:0] pb [0:DEPTH-1];

    // MAC model: go starts it, it accumulates while busy, and stop raises done on the next cycle.
    logic never_done = 1'b0;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    logic [ACC_W-1:0] m_acc = '0;

    always @(posedge clk) begin
        if (bus.mac_rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_acc  <= '0;
        end else begin
            if (bus.mac_go && !m_busy && !m_done) m_busy <= 1'b1;
            if (m_busy) begin
                m_acc <= m_acc + ACC_W'(bus.mac_a) * ACC_W'(bus.mac_b);
                if (bus.mac_stop) begin
                    m_busy <= 1'b0;
                    m_done <= !never_done;
                end
            end
        end
    end

    assign bus.mac_busy   = m_busy;
    assign bus.mac_done   = m_done;
    assign bus.mac_result = m_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.res_valid) rv_cycles++;
            if (bus.mac_go) go_cycles++;
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d with nothing expected", bus.res_data);
                end else begin
                    check("result", 32'(bus.res_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input int i, input int a, input int b);
        pa[i] = DATA_W'(a);
        pb[i] = DATA_W'(b);
    endtask

    task automatic start_job(input int len);
        bus.job_start = 1'b1;
        bus.job_len   = LEN_W'(len);
        tick();
        bus.job_start = 1'b0;
    endtask

    // vpat bit c gives in_valid for the c-th fill cycle.
    task automatic fill(input int len, input logic [31:0] vpat);
        int k = 0;
        int cyc = 0;
        while (k < len && cyc < 32) begin
            if (vpat[cyc] && !bus.in_ready) check("in_ready_fill", 32'(bus.in_ready), 32'd1);
            bus.in_valid = vpat[cyc];
            bus.in_a     = pa[k];
            bus.in_b     = pb[k];
            tick();
            if (vpat[cyc]) k++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("in_ready_drop", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_res(input string name);
        int n = 0;
        while (!bus.res_valid && n < 200) begin
            tick();
            n++;
        end
        if (!bus.res_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: res_valid not seen within 200 cycles", name);
        end
    endtask

    initial begin
        int rv0;
        int go0;
        int n;
        bus.job_start = 1'b0;
        bus.job_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b1;

        #1;
        check("rst_mac_rst", 32'(bus.mac_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mac_go", 32'(bus.mac_go), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_mac_rst", 32'(bus.mac_rst), 32'd0);

        // T1: four pairs give 1*2+3*4+5*6+7*8 = 100.
        set_pair(0, 1, 2); set_pair(1, 3, 4); set_pair(2, 5, 6); set_pair(3, 7, 8);
        exp_q.push_back(20'd100);
        rv0 = rv_cycles;
        start_job(4);
        check("t1_busy", 32'(busy), 32'd1);
        fill(4, 32'hFFFF_FFFF);
        check("t1_clr_mac_rst", 32'(bus.mac_rst), 32'd1);
        tick();
        check("t1_mac_go", 32'(bus.mac_go), 32'd1);
        wait_res("t1");
        tick();
        check("t1_res_valid_low", 32'(bus.res_valid), 32'd0);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_one_valid", 32'(rv_cycles - rv0), 32'd1);

        // T2: job lengths 0 and DEPTH+1 are illegal.
        go0 = go_cycles;
        start_job(0);
        check("t2_err0", 32'(err), 32'd1);
        check("t2_in_ready0", 32'(bus.in_ready), 32'd0);
        tick();
        check("t2_err0_pulse", 32'(err), 32'd0);
        start_job(DEPTH + 1);
        check("t2_err17", 32'(err), 32'd1);
        check("t2_busy17", 32'(busy), 32'd0);
        tick();
        check("t2_err17_pulse", 32'(err), 32'd0);
        check("t2_in_ready17", 32'(bus.in_ready), 32'd0);
        check("t2_no_go", 32'(go_cycles - go0), 32'd0);

        // T3: gaps in in_valid, three (2,3) pairs give 18.
        set_pair(0, 2, 3); set_pair(1, 2, 3); set_pair(2, 2, 3);
        exp_q.push_back(20'd18);
        start_job(3);
        fill(3, 32'b10101);
        wait_res("t3");
        tick();
        check("t3_idle", 32'(busy), 32'd0);

        // T4: result held while res_ready is low; job_start is ignored meanwhile.
        set_pair(0, 10, 10); set_pair(1, 1, 2);
        bus.res_ready = 1'b0;
        exp_q.push_back(20'd102);
        start_job(2);
        fill(2, 32'hFFFF_FFFF);
        wait_res("t4");
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                bus.job_start = 1'b1;
                bus.job_len   = LEN_W'(1);
            end
            check("t4_hold_valid", 32'(bus.res_valid), 32'd1);
            check("t4_hold_data", 32'(bus.res_data), 32'd102);
            check("t4_no_fill", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.job_start = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        check("t4_idle", 32'(busy), 32'd0);

        // T5: reset asserted mid-stream, then a fresh job (4,4),(1,1) gives 17.
        set_pair(0, 1, 1); set_pair(1, 2, 2); set_pair(2, 3, 3); set_pair(3, 4, 4);
        start_job(4);
        fill(4, 32'hFFFF_FFFF);
        n = 0;
        while (bus.mac_a == '0 && n < 100) begin
            tick();
            n++;
        end
        check("t5_reached_stream", 32'(bus.mac_a != '0), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_mac_rst", 32'(bus.mac_rst), 32'd1);
        check("t5_rst_mac_a", 32'(bus.mac_a), 32'd0);
        check("t5_rst_mac_stop", 32'(bus.mac_stop), 32'd0);
        check("t5_rst_mac_go", 32'(bus.mac_go), 32'd0);
        check("t5_rst_res_data", 32'(bus.res_data), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        set_pair(0, 4, 4); set_pair(1, 1, 1);
        exp_q.push_back(20'd17);
        start_job(2);
        fill(2, 32'hFFFF_FFFF);
        wait_res("t5");
        tick();

        // T6: MAC never signals done, so the job times out after TMO cycles in STOP.
        never_done = 1'b1;
        set_pair(0, 3, 3);
        start_job(1);
        fill(1, 32'hFFFF_FFFF);
        n = 0;
        while (!bus.mac_stop && n < 100) begin
            tick();
            n++;
        end
        check("t6_saw_stop", 32'(bus.mac_stop), 32'd1);
        n = 0;
        while (!err && n < 100) begin
            tick();
            n++;
        end
        check("t6_tmo_cycles", 32'(n), 32'(TMO + 1));
        check("t6_clr_mac_rst", 32'(bus.mac_rst), 32'd1);
        check("t6_no_valid", 32'(bus.res_valid), 32'd0);
        tick();
        check("t6_err_pulse", 32'(err), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);
        never_done = 1'b0;

        // Recovery after the timeout: (5,5) gives 25.
        set_pair(0, 5, 5);
        exp_q.push_back(20'd25);
        start_job(1);
        fill(1, 32'hFFFF_FFFF);
        wait_res("recover");
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
